// File: rtl/restoring_divider_if.sv
// restoring_divider_if
//   Host <-> divider handshake and operand/result bundle.
//   master : host side   (drives START, DIVIDEND, DIVISOR; reads results)
//   slave  : divider side (reads request/operands; drives results and status)
//   Signals: START, DIVIDEND[size], DIVISOR[size], QUOTIENT[size], REMAINDER[size],
//            DONE, BUSY, DIV_BY_ZERO
interface restoring_divider_if #(
    parameter int unsigned size = 8
);
    logic            START;
    logic [size-1:0] DIVIDEND;
    logic [size-1:0] DIVISOR;
    logic [size-1:0] QUOTIENT;
    logic [size-1:0] REMAINDER;
    logic            DONE;
    logic            BUSY;
    logic            DIV_BY_ZERO;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  QUOTIENT, REMAINDER, DONE, BUSY, DIV_BY_ZERO
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output QUOTIENT, REMAINDER, DONE, BUSY, DIV_BY_ZERO
    );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider
//   Unsigned sequential restoring divider, size-bit / size-bit. One quotient bit
//   is resolved per SHIFT+SUB pair (2 cycles per bit). Division by zero finishes
//   immediately with QUOTIENT all-ones, REMAINDER = DIVIDEND and DIV_BY_ZERO set.
//   Ports:
//     CLOCK  in  system clock (rising edge)
//     RESET  in  synchronous, active-high; aborts any operation, clears all state
//     bus    restoring_divider_if.slave: START/DIVIDEND/DIVISOR in,
//            QUOTIENT/REMAINDER/DONE/BUSY/DIV_BY_ZERO out
module restoring_divider #(
    parameter int unsigned size = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    restoring_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(size + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SUB, FINISH} state_t;

    state_t          state, state_next;

    logic [size:0]   a;          // partial remainder; top bit carries the trial-subtract borrow
    logic [size-1:0] q;
    logic [size-1:0] m;
    logic [CW-1:0]   count;

    logic [size-1:0] quotient_r;
    logic [size-1:0] remainder_r;
    logic            dbz_r;

    logic [size:0]   diff;
    logic            borrow;
    logic [size:0]   a_sub;
    logic [size-1:0] q_sub;

    // Trial subtract; a borrow means the divisor did not fit, so A is kept (restore).
    always_comb begin
        diff   = a - {1'b0, m};
        borrow = diff[size];
        a_sub  = borrow ? a : diff;
        q_sub  = {q[size-1:1], ~borrow};
    end

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.START) state_next = (bus.DIVISOR == '0) ? FINISH : SHIFT;
            SHIFT:   state_next = SUB;
            SUB:     state_next = (count == '0) ? FINISH : SHIFT;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        bus.BUSY = (state != IDLE);
        bus.DONE = (state == FINISH);
    end

    // Datapath. Results are loaded on the edge that enters FINISH (using the
    // final SUB outcome directly) so they are already valid during the DONE cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        a     <= '0;
                        q     <= bus.DIVIDEND;
                        m     <= bus.DIVISOR;
                        count <= CW'(size);
                        dbz_r <= 1'b0;
                        if (bus.DIVISOR == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.DIVIDEND;
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    {a, q} <= {a[size-1:0], q, 1'b0};
                    count  <= count - CW'(1);
                end
                SUB: begin
                    a <= a_sub;
                    q <= q_sub;
                    if (count == '0) begin
                        quotient_r  <= q_sub;
                        remainder_r <= a_sub[size-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.QUOTIENT    = quotient_r;
    assign bus.REMAINDER   = remainder_r;
    assign bus.DIV_BY_ZERO = dbz_r;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
//   Self-checking bench for restoring_divider (size = 8). A transaction-level
//   reference model (plain / and %, plus a latency countdown) predicts every
//   output each cycle; directed cases pin the model with literal expectations,
//   followed by 1000 random non-zero-divisor operations.
module tb_restoring_divider;
    localparam int unsigned SIZE = 8;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    restoring_divider_if #(.size(SIZE)) bus ();

    restoring_divider #(.size(SIZE)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_live = 0;
    bit              m_busy = 0;
    bit              m_done = 0;
    bit              m_dbz  = 0;
    logic [SIZE-1:0] m_q = '0, m_r = '0;
    logic [SIZE-1:0] p_q, p_r, p_dvd, p_dvs;
    int unsigned     m_left = 0;

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_live = 1; m_busy = 0; m_done = 0; m_dbz = 0; m_q = '0; m_r = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_q = p_q; m_r = p_r;
            end
        end else if (bus.START) begin
            p_dvd  = bus.DIVIDEND;
            p_dvs  = bus.DIVISOR;
            m_busy = 1;
            m_dbz  = 0;
            if (p_dvs != 0) begin
                p_q    = p_dvd / p_dvs;
                p_r    = p_dvd % p_dvs;
                m_left = 2 * SIZE;
            end else begin
                p_q = '1; p_r = p_dvd;
                m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 1;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (m_live) begin
            check("busy", 32'(bus.BUSY), 32'(m_busy));
            check("done", 32'(bus.DONE), 32'(m_done));
            check("dbz", 32'(bus.DIV_BY_ZERO), 32'(m_dbz));
            check("quotient", 32'(bus.QUOTIENT), 32'(m_q));
            check("remainder", 32'(bus.REMAINDER), 32'(m_r));
            if (m_done && !m_dbz) begin
                check("invariant", 32'(bus.QUOTIENT) * 32'(p_dvs) + 32'(bus.REMAINDER), 32'(p_dvd));
                check("rem_lt_div", 32'(bus.REMAINDER < p_dvs), 32'd1);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Starts one op from IDLE, waits (bounded) for DONE, checks latency in edges
    // after the accept edge, then steps one edge so the DUT is back in IDLE.
    task automatic run_op(input logic [SIZE-1:0] dvd, input logic [SIZE-1:0] dvs,
                          input logic [SIZE-1:0] eq, input logic [SIZE-1:0] er,
                          input bit edbz, input string tag);
        int unsigned n;
        bus.DIVIDEND = dvd;
        bus.DIVISOR  = dvs;
        bus.START    = 1'b1;
        @(posedge CLOCK); #1;
        bus.START    = 1'b0;
        bus.DIVIDEND = SIZE'($urandom);
        bus.DIVISOR  = SIZE'($urandom);
        n = 0;
        while (!bus.DONE && n < 100) begin
            @(posedge CLOCK); #1;
            n++;
        end
        check({tag, "_latency"}, n, (dvs == 0) ? 0 : 2 * SIZE);
        check({tag, "_q"}, 32'(bus.QUOTIENT), 32'(eq));
        check({tag, "_r"}, 32'(bus.REMAINDER), 32'(er));
        check({tag, "_dbz"}, 32'(bus.DIV_BY_ZERO), 32'(edbz));
        @(posedge CLOCK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit saw_done;
        logic [SIZE-1:0] x, y;

        bus.START    = 1'b0;
        bus.DIVIDEND = '0;
        bus.DIVISOR  = '0;
        RESET        = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_q", 32'(bus.QUOTIENT), 32'd0);
        check("rst_r", 32'(bus.REMAINDER), 32'd0);
        check("rst_dbz", 32'(bus.DIV_BY_ZERO), 32'd0);
        @(posedge CLOCK); #1;

        run_op(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, "d100_7");
        run_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, "d255_1");
        run_op(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, "d5_9");
        run_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, "d255_255");
        run_op(8'd128, 8'd16,  8'd8,   8'd0,   1'b0, "d128_16");
        run_op(8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1, "d200_0");
        run_op(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, "d9_3");

        // START re-pulsed with other operands mid-operation must be ignored
        bus.DIVIDEND = 8'd100;
        bus.DIVISOR  = 8'd7;
        bus.START    = 1'b1;
        @(posedge CLOCK); #1;
        n = 0;
        while (!bus.DONE && n < 100) begin
            if (n == 4) begin
                bus.START = 1'b1; bus.DIVIDEND = 8'd50; bus.DIVISOR = 8'd5;
            end else begin
                bus.START = 1'b0;
            end
            @(posedge CLOCK); #1;
            n++;
        end
        bus.START = 1'b0;
        check("repulse_latency", n, 2 * SIZE);
        check("repulse_q", 32'(bus.QUOTIENT), 32'd14);
        check("repulse_r", 32'(bus.REMAINDER), 32'd2);
        @(posedge CLOCK); #1;

        // Reset in the middle of an operation aborts it
        bus.DIVIDEND = 8'd100;
        bus.DIVISOR  = 8'd7;
        bus.START    = 1'b1;
        @(posedge CLOCK); #1;
        bus.START = 1'b0;
        repeat (5) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_q", 32'(bus.QUOTIENT), 32'd0);
        check("midrst_r", 32'(bus.REMAINDER), 32'd0);
        saw_done = 0;
        repeat (20) begin
            saw_done |= bus.DONE;
            @(posedge CLOCK); #1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_op(8'd77, 8'd10, 8'd7, 8'd7, 1'b0, "d77_10");

        // Random operations; small divisors are favoured half the time
        for (int i = 0; i < 1000; i++) begin
            x = SIZE'($urandom_range(0, 255));
            y = (i % 2 == 0) ? SIZE'($urandom_range(1, 255)) : SIZE'($urandom_range(1, 15));
            run_op(x, y, x / y, x % y, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
